// File: rtl/seg_pkg.sv
// Shared definitions for the 6-digit dynamic 7-segment scanner.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  // Active-low glyphs, bit 7 = DP, bits 6:0 = G..A
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  function automatic logic [7:0] digit_glyph(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  // Double-dabble correction: add 3 to every nibble that is 5 or more
  function automatic logic [23:0] bcd_adjust(input logic [23:0] acc);
    logic [23:0] r;
    r = acc;
    for (int unsigned n = 0; n < NUM_DIGITS; n++) begin
      if (r[4*n +: 4] >= 4'd5) r[4*n +: 4] = r[4*n +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Free-running sequential double-dabble: 20-bit binary to 6 BCD digits.
// bcd is the working accumulator; it is final only while bcd_vld is high.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] bin,
  output logic [23:0] bcd,
  output logic        bcd_vld
);

  bcd_state_e  r_state;
  bcd_state_e  w_next;
  logic [4:0]  r_bit;
  logic [19:0] r_bin;
  logic [23:0] r_acc;
  logic [23:0] w_adj;
  logic        w_load;
  logic        w_shift;

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= IDLE;
    else            r_state <= w_next;
  end

  // Next-state logic: IDLE (1) -> SHIFT (20) -> DONE (1)
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = SHIFT;
      SHIFT:   if (r_bit == 5'd19) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    w_load  = 1'b0;
    w_shift = 1'b0;
    bcd_vld = 1'b0;
    unique case (r_state)
      IDLE:    w_load  = 1'b1;
      SHIFT:   w_shift = 1'b1;
      DONE:    bcd_vld = 1'b1;
      default: ;
    endcase
  end

  assign w_adj = bcd_adjust(r_acc);
  assign bcd   = r_acc;

  // Shift datapath
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bin <= '0;
      r_acc <= '0;
      r_bit <= '0;
    end else if (w_load) begin
      r_bin <= bin;
      r_acc <= '0;
      r_bit <= '0;
    end else if (w_shift) begin
      r_acc <= {w_adj[22:0], r_bin[19]};
      r_bin <= {r_bin[18:0], 1'b0};
      r_bit <= r_bit + 5'd1;
    end
  end

endmodule

// File: rtl/seg_dyn_scan.sv
// 6-digit common-anode 7-segment scanner feeding a 74HC595 shifter.
module seg_dyn_scan
  import seg_pkg::*;
#(
  parameter logic [15:0] CNT_1MS  = 16'd49_999,
  parameter logic [19:0] DATA_MAX = 20'd999_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        sign,
  input  logic        seg_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  logic [19:0] w_data_sat;
  logic [23:0] w_bcd;
  logic        w_bcd_vld;
  logic [23:0] r_bcd_disp;
  logic [15:0] r_cnt_1ms;
  logic [2:0]  r_idx;
  logic [5:0]  w_blank;
  logic [5:0]  w_minus;
  logic [3:0]  w_digit;
  logic [7:0]  w_glyph;

  assign w_data_sat = (data > DATA_MAX) ? DATA_MAX : data;

  bin2bcd_seq u_bcd (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bin       (w_data_sat),
    .bcd       (w_bcd),
    .bcd_vld   (w_bcd_vld)
  );

  // Display register: take the accumulator only when the converter is in DONE
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)     r_bcd_disp <= '0;
    else if (w_bcd_vld) r_bcd_disp <= w_bcd;
  end

  // Slot timer and digit index
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt_1ms <= '0;
      r_idx     <= '0;
    end else if (r_cnt_1ms == CNT_1MS) begin
      r_cnt_1ms <= '0;
      r_idx     <= (r_idx == 3'(NUM_DIGITS - 1)) ? '0 : r_idx + 3'd1;
    end else begin
      r_cnt_1ms <= r_cnt_1ms + 16'd1;
    end
  end

  // Leading-zero blanking and placement of the minus sign
  always_comb begin
    w_blank = '0;
    w_minus = '0;
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      w_blank[i] = ((r_bcd_disp >> (4 * i)) == 24'd0) && ((point >> i) == 6'd0);
    end
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      w_minus[i] = sign && w_blank[i] && !w_blank[i-1];
    end
  end

  // Glyph for the digit currently being scanned
  always_comb begin
    w_digit = r_bcd_disp[{r_idx, 2'b00} +: 4];
    if (w_minus[r_idx])      w_glyph = SEG_MINUS;
    else if (w_blank[r_idx]) w_glyph = SEG_BLANK;
    else                     w_glyph = digit_glyph(w_digit);
    if (point[r_idx]) w_glyph[7] = 1'b0;
  end

  // Registered outputs to the shifter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel <= '0;
      seg <= SEG_BLANK;
    end else if (seg_en) begin
      sel <= 6'd1 << r_idx;
      seg <= w_glyph;
    end else begin
      sel <= '0;
      seg <= SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_seg_dyn_scan.sv
// Self-checking bench for seg_dyn_scan with a short scan slot.
module tb_seg_dyn_scan;

  localparam logic [15:0] CNT  = 16'd9;
  localparam int unsigned SLOT = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] data = '0;
  logic [5:0]  point = '0;
  logic        sign = 1'b0;
  logic        seg_en = 1'b0;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    logic [5:0] sel;
    logic [7:0] seg;
    string      name;
  } exp_t;

  typedef struct {
    string       name;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic [47:0] exp_seg;  // digit i glyph at [8*i +: 8]
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];

  seg_dyn_scan #(.CNT_1MS(CNT), .DATA_MAX(20'd999_999)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .data      (data),
    .point     (point),
    .sign      (sign),
    .seg_en    (seg_en),
    .sel       (sel),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: on every change of sel, pop and compare the next expected slot
  logic [5:0]  mon_prev_sel = '0;
  int unsigned mon_gap = 0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      mon_gap++;
      if (sel !== mon_prev_sel) begin
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check({e.name, " sel"}, 32'(sel), 32'(e.sel));
          check({e.name, " seg"}, 32'(seg), 32'(e.seg));
          check({e.name, " slot_len"}, mon_gap, SLOT);
        end
        mon_prev_sel = sel;
        mon_gap = 0;
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int unsigned k;
    @(negedge clk);
    data  = v.data;
    point = v.point;
    sign  = v.sign;
    repeat (50) @(negedge clk);
    k = 0;
    while (sel !== 6'h20 && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (sel !== 6'h20) begin
      check({v.name, " sync"}, 32'(sel), 32'h20);
    end else begin
      for (int i = 0; i < 6; i++) begin
        sb_q.push_back('{sel: 6'(1 << i), seg: v.exp_seg[8*i +: 8], name: v.name});
      end
      k = 0;
      while (sb_q.size() > 0 && k < 100) begin
        @(negedge clk);
        k++;
      end
      check({v.name, " drained"}, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned k;
    int unsigned nvld;
    int unsigned seen_at;
    int unsigned vld_at;
    logic        bad;
    int          idx;

    vecs[0] = '{"v123456",      20'd123456,  6'b000000, 1'b0, 48'hF9A4B0999282};
    vecs[1] = '{"v5_dp1_neg",   20'd5,       6'b000010, 1'b1, 48'hFFFFFFBF4092};
    vecs[2] = '{"v0",           20'd0,       6'b000000, 1'b0, 48'hFFFFFFFFFFC0};
    vecs[3] = '{"vsat_neg",     20'hFFFFF,   6'b000000, 1'b1, 48'h909090909090};
    vecs[4] = '{"v0_neg",       20'd0,       6'b000000, 1'b1, 48'hFFFFFFFFBFC0};
    vecs[5] = '{"v999999_dp",   20'd999999,  6'b100001, 1'b0, 48'h109090909010};
    vecs[6] = '{"v1000000",     20'd1000000, 6'b000000, 1'b0, 48'h909090909090};
    vecs[7] = '{"v42_dp5_neg",  20'd42,      6'b100000, 1'b1, 48'h40C0C0C099A4};
    vecs[8] = '{"v123456_neg",  20'd123456,  6'b000000, 1'b1, 48'hF9A4B0999282};
    vecs[9] = '{"v456",         20'd456,     6'b000000, 1'b0, 48'hFFFFFF999282};

    // Reset while scanning mid-slot
    data = 20'd123456; point = '0; sign = 1'b0; seg_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst sel", 32'(sel), 32'h00);
    check("async_rst seg", 32'(seg), 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst sel", 32'(sel), 32'h01);
    check("post_rst seg", 32'(seg), 32'hC0);
    k = 1;
    while (sel === 6'h01 && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    check("first_slot_len", k, SLOT + 1);
    check("second_slot sel", 32'(sel), 32'h02);

    // Table vectors through the scoreboard
    seg_en = 1'b1;
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Data change in the middle of a conversion pass
    @(negedge clk);
    data = 20'd123; point = '0; sign = 1'b0;
    repeat (50) @(negedge clk);
    check("disp_123", 32'(dut.r_bcd_disp), 32'h000123);
    k = 0;
    while (dut.w_bcd_vld !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("vld_seen", 32'(dut.w_bcd_vld), 32'd1);
    repeat (8) @(negedge clk);
    data = 20'd456;
    nvld = 0; seen_at = 0; vld_at = 0; bad = 1'b0;
    for (int unsigned c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (dut.r_bcd_disp !== 24'h000123 && dut.r_bcd_disp !== 24'h000456) bad = 1'b1;
      if (seen_at == 0 && dut.r_bcd_disp === 24'h000456) begin
        seen_at = c;
        vld_at  = nvld;
      end
      if (dut.w_bcd_vld === 1'b1) nvld++;
    end
    check("midshift no_intermediate", 32'(bad), 32'd0);
    check("midshift passes_before_456", vld_at, 32'd2);
    check("midshift latency_le_44", 32'(seen_at >= 1 && seen_at <= 44), 32'd1);
    run_vec(vecs[9]);

    // seg_en off then back on
    @(negedge clk);
    seg_en = 1'b0;
    @(posedge clk); #1;
    check("seg_en_off sel", 32'(sel), 32'h00);
    check("seg_en_off seg", 32'(seg), 32'hFF);
    repeat (3) @(negedge clk);
    check("seg_en_off_hold sel", 32'(sel), 32'h00);
    seg_en = 1'b1;
    @(posedge clk); #1;
    check("seg_en_on onehot", 32'($onehot(sel)), 32'd1);
    idx = 0;
    for (int i = 0; i < 6; i++) if (sel[i]) idx = i;
    check("seg_en_on seg", 32'(seg), 32'(vecs[9].exp_seg[8*idx +: 8]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_dyn_scan.md
Name: seg_dyn_scan

Overview:
- Upstream driver for the 74HC595 serial shifter stage. Takes a binary value plus decimal-point, sign and enable controls.
- Converts the value to six BCD digits and time-multiplexes them onto a 6-digit common-anode 7-segment display.
- Outputs a one-hot digit select `sel` and an active-low segment pattern `seg`, which feed the shifter directly.

Parameters:
- CNT_1MS, 16'd49_999: sys_clk cycles per digit slot, minus 1 (1 ms at 50 MHz).
- DATA_MAX, 20'd999_999: saturation limit for input data.

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst_n  input  1  asynchronous active-low reset.
- data  input  20  unsigned binary value to display.
- point  input  6  decimal-point enable; point[i]=1 lights the DP of digit i.
- sign  input  1  1 = show '-' in front of the number.
- seg_en  input  1  1 = display on; 0 = all digits off.
- sel  output  6  one-hot digit select, active-high. sel[0] = rightmost digit (units), sel[5] = leftmost.
- seg  output  8  segment pattern, active-low. seg[7]=DP, seg[6:0]=G..A.

Behaviour:
- Reset (asynchronous, sys_rst_n=0):
  - sel=6'b000000, seg=8'hFF.
  - Scan counter=0, digit index=0.
  - BCD display register all zero; converter idle.
- Saturation: value converted = (data > DATA_MAX) ? DATA_MAX : data.
- BCD conversion (sequential double-dabble, free-running):
  - IDLE: sample the saturated data into a 20-bit shift register and clear a 24-bit BCD accumulator. Go to SHIFT.
  - SHIFT: 20 cycles. Each cycle, add 3 to every BCD nibble ≥5, then shift left by 1, taking the binary MSB in.
  - DONE: copy the accumulator to the display register in one cycle, then go to IDLE.
  - Period is 22 cycles. The display register changes only in DONE, so it is never seen half-converted.
  - data is sampled only in IDLE; changes during SHIFT are ignored until the next pass.
  - Latency from a data change to the display register: ≤44 cycles.
- Scan timing:
  - cnt_1ms counts 0..CNT_1MS and wraps.
  - At cnt_1ms==CNT_1MS the digit index advances 0→1→…→5→0.
- Output register: sel and seg are registered together, one cycle after the digit index changes.
  - sel = 1<<index.
  - seg = glyph(index) with the DP bit cleared when point[index]=1.
- Blanking rule: digit i is blanked iff all three hold:
  - i≥1;
  - BCD digits i..5 are all zero;
  - point[5:i]==0.
- Minus rule:
  - Digit i shows '-' iff sign=1, digit i is blanked, and digit i-1 is not blanked.
  - If all six digits are significant, '-' is not shown.
- Glyphs:
  - 0..9: C0,F9,A4,B0,99,92,82,F8,80,90.
  - Blank: FF. Minus: BF.
- seg_en handling:
  - seg_en=0: sel=0 and seg=8'hFF from the next cycle; scanning and conversion continue internally.
  - seg_en 0→1: output resumes at the current index on the next cycle, with no restart.
- point, sign and seg_en are sampled combinationally at output-register time, with no additional latency.

Decomposition:
- Shared package `seg_pkg`:
  - glyph constants SEG_0..SEG_9, SEG_BLANK, SEG_MINUS;
  - NUM_DIGITS=6;
  - converter state encodings IDLE/SHIFT/DONE.
- One sub-module, `bin2bcd_seq`:
  - inputs: bin[19:0];
  - outputs: bcd[23:0] plus a one-cycle `bcd_vld` pulse when the register updates.
- The top module holds the saturation logic, scan counter, blanking/minus logic, glyph lookup and output register.

Test Plan:
- Reset while scanning mid-slot, with data=123456 → sel=0 and seg=FF immediately; after release, the first scan slot starts with cnt_1ms=0.
- data=123456, point=0, sign=0, seg_en=1, CNT_1MS=9 for sim:
  - slots produce sel=01/seg=82, 02/92, 04/99, 08/B0, 10/A4, 20/F9, then repeat;
  - each slot lasts 10 cycles.
- data=5, point=6'b000010, sign=1:
  - digit0=92 (5), digit1=40 (0 with DP), digit2=BF (-);
  - digits 3..5=FF.
- data=0, point=0 → digit0=C0, all others FF.
- data=20'hFFFFF → displays 999999 (all digits 90). With sign=1 there is no '-'.
- data changed 123→456 mid-SHIFT → display shows 123 until DONE, then 456 within 44 cycles, with no intermediate value. Then seg_en=0 → sel=0, seg=FF the next cycle.
